// File: rtl/display_serial_rx_if.sv
// Signal bundle for the 4-wire serial display link and its decoded outputs.
// The link driver uses master; the receiver uses slave.
interface display_serial_rx_if #(
  parameter int FRAME_BITS = 16
);
  logic                  value_in;
  logic                  enable_in;
  logic                  data_clk_in;
  logic                  board_clk_in;
  logic [FRAME_BITS-1:0] value_bcd;
  logic                  value_valid;
  logic                  bcd_error;
  logic                  frame_error;
  logic [7:0]            frame_count;

  modport master (
    output value_in, enable_in, data_clk_in, board_clk_in,
    input  value_bcd, value_valid, bcd_error, frame_error, frame_count
  );

  modport slave (
    input  value_in, enable_in, data_clk_in, board_clk_in,
    output value_bcd, value_valid, bcd_error, frame_error, frame_count
  );
endinterface

// File: rtl/display_serial_rx.sv
// Receiver for the serial display link: synchronises the four lines, shifts
// in one MSB-first frame and commits it as a BCD word on the board_clk strobe.
module display_serial_rx #(
  parameter int FRAME_BITS     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset_in,
  display_serial_rx_if.slave     bus
);

  localparam int L_VAL  = 0;
  localparam int L_EN   = 1;
  localparam int L_DCLK = 2;
  localparam int L_BCLK = 3;
  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FULL} state_t;

  logic [3:0]            r_sync [SYNC_STAGES];
  logic [3:0]            r_edge;
  logic [3:0]            w_lines;
  logic [3:0]            w_sync;
  logic                  w_en_rise;
  logic                  w_en_fall;
  logic                  w_dclk_rise;
  logic                  w_bclk_rise;
  logic                  w_timeout;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [TO_W-1:0]       r_timeout;
  logic [FRAME_BITS-1:0] r_value;
  logic                  r_value_valid;
  logic                  r_bcd_error;
  logic                  r_frame_error;
  logic [7:0]            r_frame_count;

  function automatic logic has_bad_nibble(input logic [FRAME_BITS-1:0] w);
    for (int i = 0; i < FRAME_BITS / 4; i++) begin
      if (w[i*4 +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  assign w_lines = {bus.board_clk_in, bus.data_clk_in, bus.enable_in, bus.value_in};

  // NOTE: the synchroniser array is small and clock-domain critical, so every
  // stage is reset; a large storage array would normally be left unreset.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_edge <= '0;
    end else begin
      r_sync[0] <= w_lines;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_edge <= w_sync;
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_en_rise   =  w_sync[L_EN]   & ~r_edge[L_EN];
  assign w_en_fall   = ~w_sync[L_EN]   &  r_edge[L_EN];
  assign w_dclk_rise =  w_sync[L_DCLK] & ~r_edge[L_DCLK];
  assign w_bclk_rise =  w_sync[L_BCLK] & ~r_edge[L_BCLK];
  assign w_timeout   = (r_timeout == TO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: all state and outputs are written with non-blocking assignments so
  // every branch sees the pre-edge values; pulse outputs default low each cycle.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_timeout     <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_bcd_error   <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_value_valid <= 1'b0;
      r_frame_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_en_rise) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= '0;
            r_timeout <= '0;
            r_shift   <= '0;
          end
        end
        S_SHIFT: begin
          if (w_en_fall || w_bclk_rise) begin
            r_frame_error <= 1'b1;
            r_state       <= S_IDLE;
          end else if (w_dclk_rise) begin
            // Data comes from the edge register: the level held just before the rise.
            r_shift   <= {r_shift[FRAME_BITS-2:0], r_edge[L_VAL]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_timeout <= '0;
            if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) r_state <= S_FULL;
          end else if (w_timeout) begin
            r_frame_error <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timeout <= r_timeout + TO_W'(1);
          end
        end
        S_FULL: begin
          if (w_dclk_rise) begin
            r_frame_error <= 1'b1;
            r_state       <= S_IDLE;
          end else if (w_bclk_rise) begin
            r_value       <= r_shift;
            r_value_valid <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
            r_bcd_error   <= has_bad_nibble(r_shift);
            r_bit_cnt     <= '0;
            r_timeout     <= '0;
            r_shift       <= '0;
            r_state       <= w_sync[L_EN] ? S_SHIFT : S_IDLE;
          end else if (w_en_fall || w_timeout) begin
            r_frame_error <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timeout <= r_timeout + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.value_bcd   = r_value;
  assign bus.value_valid = r_value_valid;
  assign bus.bcd_error   = r_bcd_error;
  assign bus.frame_error = r_frame_error;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_display_serial_rx.sv
// Directed bench for display_serial_rx: drives link frames and checks the
// decoded word, pulses, counters and error handling against fixed values.
module tb_display_serial_rx;

  localparam int PH = 2;

  logic clk;
  logic reset_in;
  int   n_checks;
  int   n_errors;
  int   n_valid;
  int   n_ferr;
  int   n_both;
  int   base_v;
  int   base_f;

  display_serial_rx_if #(.FRAME_BITS(16)) bus ();

  display_serial_rx #(
    .FRAME_BITS    (16),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.value_valid) n_valid++;
    if (bus.frame_error) n_ferr++;
    if (bus.value_valid && bus.frame_error) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.value_in = b;
    wait_cyc(PH);
    bus.data_clk_in = 1'b1;
    wait_cyc(PH);
    bus.data_clk_in = 1'b0;
    wait_cyc(PH);
  endtask

  task automatic send_bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[15-i]);
  endtask

  task automatic start_frame();
    bus.enable_in = 1'b1;
    wait_cyc(PH);
  endtask

  // last=1 drops enable on the same cycle as the strobe, ending the burst cleanly.
  task automatic latch(input bit last);
    bus.board_clk_in = 1'b1;
    if (last) bus.enable_in = 1'b0;
    wait_cyc(PH);
    bus.board_clk_in = 1'b0;
    wait_cyc(PH);
  endtask

  task automatic send_frame(input logic [15:0] d, input bit last);
    send_bits(d, 16);
    latch(last);
    wait_cyc(8);
  endtask

  task automatic pulse_reset();
    reset_in = 1'b0;
    wait_cyc(3);
    reset_in = 1'b1;
    wait_cyc(3);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_valid  = 0;
    n_ferr   = 0;
    n_both   = 0;
    reset_in = 1'b0;
    bus.value_in     = 1'b0;
    bus.enable_in    = 1'b0;
    bus.data_clk_in  = 1'b0;
    bus.board_clk_in = 1'b0;
    wait_cyc(3);

    check("rst_value", 32'(bus.value_bcd), 32'h0);
    check("rst_valid", 32'(bus.value_valid), 32'h0);
    check("rst_bcderr", 32'(bus.bcd_error), 32'h0);
    check("rst_ferr", 32'(bus.frame_error), 32'h0);
    check("rst_count", 32'(bus.frame_count), 32'h0);
    reset_in = 1'b1;
    wait_cyc(4);

    // Single frame, enable dropped together with the strobe
    base_v = n_valid; base_f = n_ferr;
    start_frame();
    send_frame(16'h1234, 1'b1);
    check("single_value", 32'(bus.value_bcd), 32'h1234);
    check("single_valid_cycles", 32'(n_valid - base_v), 32'd1);
    check("single_count", 32'(bus.frame_count), 32'd1);
    check("single_bcderr", 32'(bus.bcd_error), 32'h0);
    check("single_ferr", 32'(n_ferr - base_f), 32'd0);

    // Back-to-back with enable held high
    pulse_reset();
    base_v = n_valid; base_f = n_ferr;
    start_frame();
    send_frame(16'h0042, 1'b0);
    check("b2b_first", 32'(bus.value_bcd), 32'h0042);
    send_frame(16'h9999, 1'b1);
    check("b2b_value", 32'(bus.value_bcd), 32'h9999);
    check("b2b_valids", 32'(n_valid - base_v), 32'd2);
    check("b2b_count", 32'(bus.frame_count), 32'd2);
    check("b2b_ferr", 32'(n_ferr - base_f), 32'd0);
    check("b2b_bcderr", 32'(bus.bcd_error), 32'h0);

    // Short frame
    base_f = n_ferr;
    start_frame();
    send_bits(16'h5555, 10);
    bus.enable_in = 1'b0;
    wait_cyc(8);
    check("short_ferr", 32'(n_ferr - base_f), 32'd1);
    check("short_value", 32'(bus.value_bcd), 32'h9999);
    check("short_count", 32'(bus.frame_count), 32'd2);

    // Invalid BCD then a clean word
    start_frame();
    send_frame(16'h12A4, 1'b1);
    check("badbcd_value", 32'(bus.value_bcd), 32'h12A4);
    check("badbcd_flag", 32'(bus.bcd_error), 32'h1);
    check("badbcd_count", 32'(bus.frame_count), 32'd3);
    start_frame();
    send_frame(16'h0000, 1'b1);
    check("goodbcd_value", 32'(bus.value_bcd), 32'h0);
    check("goodbcd_flag", 32'(bus.bcd_error), 32'h0);
    check("goodbcd_count", 32'(bus.frame_count), 32'd4);

    // Overrun: 17 bits; the late strobe lands in IDLE and is ignored
    base_f = n_ferr; base_v = n_valid;
    start_frame();
    send_bits(16'hFFFF, 16);
    send_bit(1'b1);
    wait_cyc(8);
    check("ovr_ferr", 32'(n_ferr - base_f), 32'd1);
    latch(1'b1);
    wait_cyc(8);
    check("ovr_ferr_after", 32'(n_ferr - base_f), 32'd1);
    check("ovr_valid", 32'(n_valid - base_v), 32'd0);
    check("ovr_value", 32'(bus.value_bcd), 32'h0);
    check("ovr_count", 32'(bus.frame_count), 32'd4);

    // Timeout after 5 bits with enable held
    base_f = n_ferr;
    start_frame();
    send_bits(16'hA800, 5);
    wait_cyc(3900);
    check("to_not_yet", 32'(n_ferr - base_f), 32'd0);
    wait_cyc(300);
    check("to_fired", 32'(n_ferr - base_f), 32'd1);
    bus.enable_in = 1'b0;
    wait_cyc(8);
    check("to_idle_no_err", 32'(n_ferr - base_f), 32'd1);
    start_frame();
    send_frame(16'h5678, 1'b1);
    check("to_recover_value", 32'(bus.value_bcd), 32'h5678);
    check("to_recover_count", 32'(bus.frame_count), 32'd5);

    // Asynchronous reset mid-frame
    start_frame();
    send_bits(16'hFFFF, 8);
    reset_in = 1'b0;
    bus.enable_in = 1'b0;
    bus.value_in  = 1'b0;
    wait_cyc(2);
    check("mid_rst_value", 32'(bus.value_bcd), 32'h0);
    check("mid_rst_count", 32'(bus.frame_count), 32'd0);
    check("mid_rst_valid", 32'(bus.value_valid), 32'h0);
    check("mid_rst_ferr", 32'(bus.frame_error), 32'h0);
    check("mid_rst_bcderr", 32'(bus.bcd_error), 32'h0);
    reset_in = 1'b1;
    wait_cyc(4);
    start_frame();
    send_frame(16'h0007, 1'b1);
    check("post_rst_value", 32'(bus.value_bcd), 32'h0007);
    check("post_rst_count", 32'(bus.frame_count), 32'd1);

    // Counter wrap: 254 more commits reach 255, one more wraps to 0
    base_v = n_valid;
    start_frame();
    for (int k = 0; k < 254; k++) send_frame(16'(k), 1'b0);
    check("wrap_255", 32'(bus.frame_count), 32'd255);
    check("wrap_last_value", 32'(bus.value_bcd), 32'h00FD);
    check("wrap_last_bcderr", 32'(bus.bcd_error), 32'h1);
    send_frame(16'h0321, 1'b1);
    check("wrap_0", 32'(bus.frame_count), 32'd0);
    check("wrap_value", 32'(bus.value_bcd), 32'h0321);
    check("wrap_bcderr", 32'(bus.bcd_error), 32'h0);
    check("wrap_valids", 32'(n_valid - base_v), 32'd255);

    check("valid_ferr_overlap", 32'(n_both), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
